// File: rtl/delay_time_controller_if.sv
// Configuration handshake bundle for delay_time_controller.
//   cfg_valid        : host requests a new target/step
//   cfg_ready        : controller accepts; transfer when cfg_valid && cfg_ready
//   cfg_target_delay : requested delay in samples (clamped by the controller)
//   cfg_step         : maximum change of the live delay per audio sample
// Modports: master = host/register block side, slave = controller side.
interface delay_time_controller_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned STEP_WIDTH = 8
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [ADDR_WIDTH-1:0] cfg_target_delay;
  logic [STEP_WIDTH-1:0] cfg_step;

  modport master (
    output cfg_valid,
    output cfg_target_delay,
    output cfg_step,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_target_delay,
    input  cfg_step,
    output cfg_ready
  );
endinterface

// File: rtl/delay_time_controller.sv
// Delay-length sequencer for the circular-buffer delay line.
// Latches a clamped target delay and a slew step from the cfg handshake and moves the live
// delay toward the target, at most one step per audio sample, to avoid clicks on changes.
//
// Ports:
//   clk            : system clock
//   reset          : synchronous, active-high reset
//   sample_valid   : audio sample strobe (one cycle per sample)
//   freeze         : hold the current delay and pause any glide
//   cfg            : configuration handshake (slave modport)
//   delay_samples  : live delay to the buffer (registered)
//   ramp_active    : high while gliding toward the target
//   target_reached : one-cycle pulse when delay_samples lands on the target
//
// Build option: define DELAY_CTRL_SLEW_EN for the stepped glide. Without it, a pending target
// is applied whole on the next unfrozen sample and ramp_active is tied low.
module delay_time_controller #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned STEP_WIDTH = 8,
  parameter int unsigned MIN_DELAY  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_valid,
  input  logic                   freeze,
  delay_time_controller_if.slave cfg,
  output logic [ADDR_WIDTH-1:0]  delay_samples,
  output logic                   ramp_active,
  output logic                   target_reached
);

  typedef enum logic [1:0] {
    StIdle,
    StRamp,
    StHold
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] MinDelay = ADDR_WIDTH'(MIN_DELAY);
  localparam logic [STEP_WIDTH-1:0] StepOne  = STEP_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] delay_q, delay_d;
  logic [ADDR_WIDTH-1:0] target_q, target_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  reached_q, reached_d;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] cfg_target_clamped;

  // Ready whenever out of reset; retargeting mid-glide is allowed.
  assign cfg.cfg_ready = ~reset;
  assign xfer          = cfg.cfg_valid & cfg.cfg_ready;

  // Upper bound is implicit in the port width; only the lower bound needs clamping.
  assign cfg_target_clamped = (cfg.cfg_target_delay < MinDelay) ? MinDelay
                                                                 : cfg.cfg_target_delay;

  always_comb begin : cfg_latch
    target_d = target_q;
    step_d   = step_q;
    if (xfer) begin
      target_d = cfg_target_clamped;
      step_d   = (cfg.cfg_step == '0) ? StepOne : cfg.cfg_step;
    end
  end

`ifdef DELAY_CTRL_SLEW_EN
  localparam int unsigned ExtWidth = ADDR_WIDTH + 1;

  logic [ExtWidth-1:0]   tgt_ext, dly_ext, step_ext, diff;
  logic                  going_up;
  logic [ADDR_WIDTH-1:0] stepped_delay;

  // One glide step from the currently latched target/step; a transfer in the same cycle only
  // affects the following sample. Moving by step only when diff > step keeps the sum in range,
  // so the truncating casts never wrap and the result never overshoots.
  always_comb begin : glide_step
    tgt_ext  = {1'b0, target_q};
    dly_ext  = {1'b0, delay_q};
    step_ext = ExtWidth'(step_q);
    going_up = (tgt_ext > dly_ext);
    diff     = going_up ? (tgt_ext - dly_ext) : (dly_ext - tgt_ext);
    if (diff <= step_ext) begin
      stepped_delay = target_q;
    end else if (going_up) begin
      stepped_delay = ADDR_WIDTH'(dly_ext + step_ext);
    end else begin
      stepped_delay = ADDR_WIDTH'(dly_ext - step_ext);
    end
  end

  always_comb begin : fsm
    logic [ADDR_WIDTH-1:0] next_delay;
    state_d    = state_q;
    delay_d    = delay_q;
    reached_d  = 1'b0;
    next_delay = delay_q;
    if (freeze) begin
      // Freeze wins over sample_valid; transfers are still latched by cfg_latch.
      state_d = StHold;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (xfer && (cfg_target_clamped == delay_q)) begin
            reached_d = 1'b1;
          end else if (target_d != delay_q) begin
            state_d = StRamp;
          end
        end
        StRamp: begin
          if (sample_valid) begin
            next_delay = stepped_delay;
          end
          delay_d = next_delay;
          // Compare against target_d so a same-cycle retarget keeps the glide going.
          if (next_delay == target_d) begin
            state_d   = StIdle;
            reached_d = 1'b1;
          end
        end
        StHold: begin
          state_d = (delay_q != target_d) ? StRamp : StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign ramp_active = (state_q == StRamp);
`else
  always_comb begin : fsm
    state_d   = state_q;
    delay_d   = delay_q;
    reached_d = 1'b0;
    if (freeze) begin
      state_d = StHold;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A pending target (possibly latched while frozen) jumps in on the next sample.
          if (sample_valid && (target_q != delay_q)) begin
            delay_d   = target_q;
            reached_d = 1'b1;
          end else if (xfer && (cfg_target_clamped == delay_q)) begin
            reached_d = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign ramp_active = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      delay_q   <= MinDelay;
      target_q  <= MinDelay;
      step_q    <= StepOne;
      reached_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      target_q  <= target_d;
      step_q    <= step_d;
      reached_q <= reached_d;
    end
  end

  assign delay_samples  = delay_q;
  assign target_reached = reached_q;

endmodule

// File: tb/tb_delay_time_controller.sv
// Directed self-checking bench for delay_time_controller. Covers the build selected by
// DELAY_CTRL_SLEW_EN (stepped glide when defined, whole-target jump otherwise).
module tb_delay_time_controller;

  logic        clk;
  logic        reset;
  logic        sample_valid;
  logic        freeze;
  logic [15:0] delay_samples;
  logic        ramp_active;
  logic        target_reached;

  int n_checks;
  int n_errors;

  delay_time_controller_if #(.ADDR_WIDTH(16), .STEP_WIDTH(8)) cfg_if ();

  delay_time_controller #(
    .ADDR_WIDTH(16),
    .STEP_WIDTH(8),
    .MIN_DELAY (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_valid  (sample_valid),
    .freeze        (freeze),
    .cfg           (cfg_if.slave),
    .delay_samples (delay_samples),
    .ramp_active   (ramp_active),
    .target_reached(target_reached)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [15:0] tgt, input logic [7:0] stp);
    cfg_if.cfg_valid        = 1'b1;
    cfg_if.cfg_target_delay = tgt;
    cfg_if.cfg_step         = stp;
    cycle();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic sample();
    sample_valid = 1'b1;
    cycle();
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  initial begin
    n_checks                = 0;
    n_errors                = 0;
    reset                   = 1'b1;
    sample_valid            = 1'b0;
    freeze                  = 1'b0;
    cfg_if.cfg_valid        = 1'b0;
    cfg_if.cfg_target_delay = 16'd0;
    cfg_if.cfg_step         = 8'd0;

    // Reset state
    cycle();
    cycle();
    check_eq("ready_in_reset", 32'(cfg_if.cfg_ready), 0);
    check_eq("delay_in_reset", 32'(delay_samples), 1);
    reset = 1'b0;
    cycle();
    check_eq("ready_after_reset", 32'(cfg_if.cfg_ready), 1);
    check_eq("ramp_after_reset", 32'(ramp_active), 0);
    check_eq("reached_after_reset", 32'(target_reached), 0);
    for (int i = 0; i < 3; i++) begin
      sample();
      check_eq("idle_delay", 32'(delay_samples), 1);
      check_eq("idle_ramp", 32'(ramp_active), 0);
      cycle();
      cycle();
      cycle();
    end

`ifdef DELAY_CTRL_SLEW_EN
    // Glide 1 -> 100 with step 30
    send_cfg(16'd100, 8'd30);
    check_eq("glide_ramp_on", 32'(ramp_active), 1);
    check_eq("glide_hold_until_sample", 32'(delay_samples), 1);
    sample();
    check_eq("glide_31", 32'(delay_samples), 31);
    check_eq("glide_no_pulse", 32'(target_reached), 0);
    sample();
    check_eq("glide_61", 32'(delay_samples), 61);
    sample();
    check_eq("glide_91", 32'(delay_samples), 91);
    sample();
    check_eq("glide_100", 32'(delay_samples), 100);
    check_eq("glide_pulse", 32'(target_reached), 1);
    check_eq("glide_ramp_off", 32'(ramp_active), 0);
    cycle();
    check_eq("glide_pulse_once", 32'(target_reached), 0);

    // Reverse mid-glide: 61 heading to 100, retarget to 10
    do_reset();
    send_cfg(16'd100, 8'd30);
    sample();
    sample();
    check_eq("rev_start_61", 32'(delay_samples), 61);
    send_cfg(16'd10, 8'd30);
    sample();
    check_eq("rev_31", 32'(delay_samples), 31);
    check_eq("rev_no_pulse", 32'(target_reached), 0);
    sample();
    check_eq("rev_10", 32'(delay_samples), 10);
    check_eq("rev_pulse", 32'(target_reached), 1);
    cycle();
    check_eq("rev_pulse_once", 32'(target_reached), 0);

    // Clamp low, then glide to full scale without wrap
    send_cfg(16'd0, 8'd255);
    sample();
    check_eq("clamp_min", 32'(delay_samples), 1);
    send_cfg(16'hFFFF, 8'd255);
    for (int k = 1; k <= 256; k++) begin
      sample();
      check_eq("full_glide", 32'(delay_samples), 32'(1 + 255 * k));
    end
    check_eq("full_glide_ramp", 32'(ramp_active), 1);
    sample();
    check_eq("full_end", 32'(delay_samples), 65535);
    check_eq("full_pulse", 32'(target_reached), 1);
    sample();
    check_eq("full_no_wrap", 32'(delay_samples), 65535);

    // Freeze at 61 for 5 samples, retarget to 200 during freeze
    do_reset();
    send_cfg(16'd100, 8'd30);
    sample();
    sample();
    freeze = 1'b1;
    cycle();
    check_eq("frz_ramp_off", 32'(ramp_active), 0);
    send_cfg(16'd200, 8'd30);
    for (int i = 0; i < 5; i++) begin
      sample();
      check_eq("frz_hold_61", 32'(delay_samples), 61);
    end
    freeze = 1'b0;
    cycle();
    check_eq("frz_release_ramp", 32'(ramp_active), 1);
    sample();
    check_eq("frz_91", 32'(delay_samples), 91);
    sample();
    check_eq("frz_121", 32'(delay_samples), 121);

    // Step 0 is treated as 1
    do_reset();
    send_cfg(16'd4, 8'd0);
    sample();
    check_eq("step0_2", 32'(delay_samples), 2);
`else
    // Whole-target jump on the next sample
    send_cfg(16'd5000, 8'd7);
    check_eq("jump_wait_delay", 32'(delay_samples), 1);
    check_eq("jump_wait_pulse", 32'(target_reached), 0);
    cycle();
    check_eq("jump_wait_delay2", 32'(delay_samples), 1);
    sample();
    check_eq("jump_5000", 32'(delay_samples), 5000);
    check_eq("jump_pulse", 32'(target_reached), 1);
    check_eq("jump_ramp", 32'(ramp_active), 0);
    cycle();
    check_eq("jump_pulse_once", 32'(target_reached), 0);

    // Equal target pulses on the cycle after the transfer
    send_cfg(16'd5000, 8'd3);
    check_eq("equal_pulse", 32'(target_reached), 1);
    cycle();
    check_eq("equal_pulse_once", 32'(target_reached), 0);

    // Clamp low and full scale
    send_cfg(16'd0, 8'd0);
    sample();
    check_eq("clamp_min", 32'(delay_samples), 1);
    check_eq("clamp_min_pulse", 32'(target_reached), 1);
    send_cfg(16'hFFFF, 8'd255);
    sample();
    check_eq("full_scale", 32'(delay_samples), 65535);

    // Freeze blocks the jump even with sample_valid, transfer still latched
    freeze = 1'b1;
    cycle();
    send_cfg(16'd200, 8'd30);
    for (int i = 0; i < 5; i++) begin
      sample();
      check_eq("frz_hold", 32'(delay_samples), 65535);
      check_eq("frz_no_pulse", 32'(target_reached), 0);
    end
    freeze = 1'b0;
    cycle();
    check_eq("frz_release_hold", 32'(delay_samples), 65535);
    sample();
    check_eq("frz_apply_200", 32'(delay_samples), 200);
    check_eq("frz_ramp", 32'(ramp_active), 0);

    // Transfer coinciding with a sample: old pending target applies first
    send_cfg(16'd300, 8'd1);
    cfg_if.cfg_valid        = 1'b1;
    cfg_if.cfg_target_delay = 16'd400;
    sample_valid            = 1'b1;
    cycle();
    cfg_if.cfg_valid = 1'b0;
    sample_valid     = 1'b0;
    check_eq("simul_old_300", 32'(delay_samples), 300);
    sample();
    check_eq("simul_new_400", 32'(delay_samples), 400);

    // Reset abandons a pending target
    send_cfg(16'd900, 8'd1);
    do_reset();
    check_eq("rst_mid_delay", 32'(delay_samples), 1);
    sample();
    check_eq("rst_mid_after_sample", 32'(delay_samples), 1);
    check_eq("rst_mid_no_pulse", 32'(target_reached), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
